// File: rtl/sync_token_arb_pkg.sv
// Shared types and constants for sync_token_arbiter: FSM state encoding,
// a constant-foldable clog2 and the default stall-timeout threshold.
package sync_token_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FULL = 2'd1,
    ST_GAP       = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_token_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, wrapping
// past N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            any_o,
  output logic [IDXW-1:0] idx_o,
  output logic [N-1:0]    onehot_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotating right by ptr puts the highest-priority request at bit 0.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    int sum;
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    any_o = 1'b0;
    idx_o = '0;
    sum   = 0;
    // Scan from the lowest priority upward; the last hit is the winner.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_o = 1'b1;
        sum   = int'(ptr_i) + k;
        if (sum >= N) sum = sum - N;
        idx_o = IDXW'(sum);
      end
    end
    onehot_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/sync_token_arbiter.sv
// Shares one zero-width SyncFIFO10 token channel among N event sources:
// per-source pending counters, round-robin pick, FULL_N-aware enqueue with a
// programmable post-enqueue gap. Define SYNC_TOKEN_ARB_TIMEOUT_EN for the
// sticky stall timeout (sTimeout); otherwise sTimeout is tied low.
module sync_token_arbiter
  import sync_token_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDXW    = 2,
  parameter int CNTW    = 4,
  parameter int GAPW    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            sCLK,
  input  logic            sRST,
  input  logic            sEnable,
  input  logic [GAPW-1:0] sGap,
  input  logic [N-1:0]    sEvt,
  input  logic            sFifoFULL_N,
  output logic            sFifoENQ,
  output logic [IDXW-1:0] sGrantIdx,
  output logic [N-1:0]    sPending,
  output logic [N-1:0]    sOvf,
  output logic            sBusy,
  output logic            sTimeout
);

  if (IDXW != clog2(N) || N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("sync_token_arbiter: IDXW must equal clog2(N), N in 2..16, TIMEOUT >= 1");
  end

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  arb_state_e                 state_q, state_d;
  logic [GAPW-1:0]            gap_q, gap_d;
  logic [IDXW-1:0]            ptr_q, ptr_d;
  logic [N-1:0][CNTW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]               ovf_q, ovf_d;

  logic                       pick_any;
  logic [IDXW-1:0]            pick_idx;
  logic [N-1:0]               pick_onehot;
  logic [N-1:0]               grant_oh;
  logic                       enq;

  always_comb begin
    for (int i = 0; i < N; i++) sPending[i] = (cnt_q[i] != '0);
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i    (sPending),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Enqueue decision is combinational so the token leaves in the same cycle
  // the pick is made.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    enq     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sEnable && pick_any) begin
          if (sFifoFULL_N) begin
            enq = 1'b1;
            if (sGap != '0) begin
              state_d = ST_GAP;
              gap_d   = sGap;
            end
          end else begin
            state_d = ST_WAIT_FULL;
          end
        end
      end
      ST_WAIT_FULL: begin
        if (sFifoFULL_N || !sEnable) state_d = ST_IDLE;
      end
      ST_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAPW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (sRST) enq = 1'b0;
  end

  assign grant_oh = {N{enq}} & pick_onehot;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < N; i++) begin
      if (sEvt[i] && !grant_oh[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!sEvt[i] && grant_oh[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (enq) ptr_d = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge sCLK) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (sRST) begin
      // NOTE: counters are explicitly cleared; pending events are dropped
      // on purpose, matching the FIFO being reset alongside this block.
      state_q <= ST_IDLE;
      gap_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sFifoENQ  = enq;
  assign sGrantIdx = enq ? pick_idx : '0;
  assign sOvf      = ovf_q;
  assign sBusy     = (state_q != ST_IDLE) || pick_any;

`ifdef SYNC_TOKEN_ARB_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        tout_q, tout_d;
  logic        stalled;

  assign stalled = pick_any && !sFifoFULL_N;

  always_comb begin
    stall_d = '0;
    tout_d  = tout_q;
    if (stalled) begin
      stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
      if (int'(stall_d) >= TIMEOUT) tout_d = 1'b1;
    end
  end

  always_ff @(posedge sCLK) begin
    if (sRST) begin
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end

  assign sTimeout = tout_q;
`else
  assign sTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_sync_token_arbiter.sv
// Self-checking bench for sync_token_arbiter: directed scenarios plus random
// traffic, all compared against a queue/array model of the arbitration rules.
module tb_sync_token_arbiter;

  localparam int N       = 4;
  localparam int IDXW    = 2;
  localparam int CNTW    = 4;
  localparam int GAPW    = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic            sCLK = 1'b0;
  logic            sRST = 1'b1;
  logic            sEnable = 1'b0;
  logic [GAPW-1:0] sGap = '0;
  logic [N-1:0]    sEvt = '0;
  logic            sFifoFULL_N = 1'b1;
  logic            sFifoENQ;
  logic [IDXW-1:0] sGrantIdx;
  logic [N-1:0]    sPending;
  logic [N-1:0]    sOvf;
  logic            sBusy;
  logic            sTimeout;

  always #5 sCLK = ~sCLK;

  sync_token_arbiter #(
    .N(N), .IDXW(IDXW), .CNTW(CNTW), .GAPW(GAPW), .TIMEOUT(TIMEOUT)
  ) dut (
    .sCLK        (sCLK),
    .sRST        (sRST),
    .sEnable     (sEnable),
    .sGap        (sGap),
    .sEvt        (sEvt),
    .sFifoFULL_N (sFifoFULL_N),
    .sFifoENQ    (sFifoENQ),
    .sGrantIdx   (sGrantIdx),
    .sPending    (sPending),
    .sOvf        (sOvf),
    .sBusy       (sBusy),
    .sTimeout    (sTimeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: pending counts, rotation pointer, blocked-cycle budget
  // after an enqueue, and a flag for "stalled on full FIFO".
  int       m_cnt[N];
  int       m_ptr;
  int       m_gap_left;
  bit       m_stall;
  bit [N-1:0] m_ovf;
  int       m_stall_cyc;
  bit       m_tout;
  bit       m_valid = 1'b0;

  int       cyc = 0;
  bit       obs_enq;
  int       obs_idx;
  logic [N-1:0] obs_pend;
  logic [N-1:0] obs_ovf;
  bit       obs_busy;
  bit       obs_tout;

  task automatic step(input bit rst, input bit en, input int gap,
                      input logic [N-1:0] evt, input bit full_n);
    int  pick;
    bit  any;
    bit  e_enq;
    int  e_idx;
    bit  e_busy;
    logic [N-1:0] e_pend;
    @(negedge sCLK);
    sRST = rst; sEnable = en; sGap = GAPW'(gap); sEvt = evt; sFifoFULL_N = full_n;
    #1;
    pick = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (pick < 0 && m_cnt[j] > 0) pick = j;
    end
    any    = (pick >= 0);
    e_enq  = !rst && !m_stall && (m_gap_left == 0) && en && any && full_n;
    e_idx  = e_enq ? pick : 0;
    e_busy = m_stall || (m_gap_left > 0) || any;
    for (int i = 0; i < N; i++) e_pend[i] = (m_cnt[i] != 0);

    if (m_valid) begin
      check("enq",     32'(sFifoENQ),  32'(e_enq));
      check("idx",     32'(sGrantIdx), e_idx);
      check("pending", 32'(sPending),  32'(e_pend));
      check("busy",    32'(sBusy),     32'(e_busy));
      check("ovf",     32'(sOvf),      32'(m_ovf));
      check("timeout", 32'(sTimeout),  32'(m_tout));
    end
    obs_enq  = sFifoENQ;
    obs_idx  = int'(sGrantIdx);
    obs_pend = sPending;
    obs_ovf  = sOvf;
    obs_busy = sBusy;
    obs_tout = sTimeout;

    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr = 0; m_gap_left = 0; m_stall = 0; m_ovf = '0;
      m_stall_cyc = 0; m_tout = 0; m_valid = 1'b1;
    end else begin
`ifdef SYNC_TOKEN_ARB_TIMEOUT_EN
      m_stall_cyc = (any && !full_n) ? m_stall_cyc + 1 : 0;
      if (m_stall_cyc >= TIMEOUT) m_tout = 1'b1;
`endif
      for (int i = 0; i < N; i++) begin
        bit g;
        g = e_enq && (pick == i);
        if (evt[i] && !g) begin
          if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
          else                  m_cnt[i]++;
        end else if (!evt[i] && g) begin
          m_cnt[i]--;
        end
      end
      if (e_enq) begin
        m_ptr      = (pick + 1) % N;
        m_gap_left = gap;
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (m_stall) begin
        if (full_n || !en) m_stall = 1'b0;
      end else if (en && any && !full_n) begin
        m_stall = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic drain(output int n_enq);
    n_enq = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 0, '0, 1);
      if (obs_enq) n_enq++;
      if (!obs_busy && !obs_enq) break;
    end
    check("drain_idle", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_idx[$];
    int q_cyc[$];
    int n;
    int t_evt;
    bit e1, e2;

    // Reset with events asserted: everything reads zero, nothing retained.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'hF, 1);
    check("rst_outputs", {obs_enq, 2'(obs_idx), obs_pend, obs_ovf, obs_busy, obs_tout}, 32'd0);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    check("rst_release_pend", 32'(obs_pend), 32'd0);
    check("rst_release_enq",  32'(obs_enq),  32'd0);

    // Round-robin: all four pending, FIFO goes not-ready for 2 cycles after each enqueue.
    step(0, 1, 0, 4'hF, 1);
    e1 = 0; e2 = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, '0, !(e1 || e2));
      e2 = e1; e1 = obs_enq;
      if (obs_enq) q_idx.push_back(obs_idx);
    end
    check("rr_count", q_idx.size(), 32'd4);
    for (int k = 0; k < q_idx.size(); k++) check("rr_order", q_idx[k], k);
    drain(n);

    // Gap of 3 between enqueues from a single source.
    q_idx.delete();
    t_evt = cyc;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 3, (i < 3) ? 4'b0010 : 4'b0000, 1);
      if (obs_enq) begin
        q_cyc.push_back(cyc - 1);
        q_idx.push_back(obs_idx);
      end
    end
    check("gap_count", q_cyc.size(), 32'd3);
    if (q_cyc.size() == 3) begin
      check("gap_latency", q_cyc[0] - t_evt, 32'd1);
      check("gap_space1",  q_cyc[1] - q_cyc[0], 32'd4);
      check("gap_space2",  q_cyc[2] - q_cyc[1], 32'd4);
      for (int k = 0; k < 3; k++) check("gap_idx", q_idx[k], 32'd1);
    end
    drain(n);

    // Backpressure: two pending while FULL_N is low.
    step(0, 1, 0, 4'b0011, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0, 0);
      n += int'(obs_enq);
    end
    check("bp_no_enq", n, 32'd0);
    check("bp_busy",   32'(obs_busy), 32'd1);
    n = 0;
    step(0, 1, 0, '0, 1); n += int'(obs_enq);
    step(0, 1, 0, '0, 1); n += int'(obs_enq);
    check("bp_release_enq", n, 32'd1);
    drain(n);

    // Saturation of source 2 with arbitration disabled.
    for (int i = 0; i < 16; i++) step(0, 0, 0, 4'b0100, 1);
    step(0, 0, 0, '0, 1);
    check("sat_ovf",  32'(obs_ovf),  32'b0100);
    check("sat_pend", 32'(obs_pend), 32'b0100);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'b0100, 1);
      n += int'(obs_enq);
    end
    check("sat_evt_grant_enq", n, 32'd5);
    drain(n);
    check("sat_count_held", n, 32'd15);

`ifdef SYNC_TOKEN_ARB_TIMEOUT_EN
    step(1, 0, 0, '0, 1);
    step(0, 1, 0, 4'b0001, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 0);
    check("tout_set", 32'(obs_tout), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 1);
    check("tout_sticky", 32'(obs_tout), 32'd1);
    drain(n);
`else
    step(0, 1, 0, 4'b0001, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 0);
    check("tout_off", 32'(obs_tout), 32'd0);
    drain(n);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 499) == 0);
      step(rst,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 3),
           N'($urandom()) & N'($urandom()),
           $urandom_range(0, 3) != 0);
    end
    drain(n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
